// File: rtl/gray_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | gray_seq_ctrl                                                              |
// | Command-driven RUN/LOAD/CLEAR sequencer for a binary-backed Gray counter.  |
// | Optional adjacency checker: define GRAY_SEQ_CHECK_EN.                      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module gray_seq_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_steps,
    input  logic [WIDTH-1:0] cmd_load,
    input  logic             pause,
    output logic [WIDTH-1:0] gray,
    output logic             busy,
    output logic             done,
    output logic             wrap,
    output logic             err
);

    localparam logic [1:0]       c_OP_UP    = 2'b00;
    localparam logic [1:0]       c_OP_DOWN  = 2'b01;
    localparam logic [1:0]       c_OP_LOAD  = 2'b10;
    localparam logic [1:0]       c_OP_CLEAR = 2'b11;
    localparam logic [WIDTH-1:0] c_ZERO     = '0;
    localparam logic [WIDTH-1:0] c_ONES     = '1;
    localparam logic [WIDTH-1:0] c_ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] c_REM_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] c_REM_ZERO = '0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_bin;
    logic [WIDTH-1:0] r_gray;
    logic [CNT_W-1:0] r_rem;
    logic             r_dir_down;
    logic             r_ready;
    logic             r_wrap;

    logic [WIDTH-1:0] w_next_bin;
    logic             w_accept;
    logic             w_step;
    logic             w_wrap_step;

    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // r_ready is only ever high in IDLE, so it doubles as the accept qualifier.
    assign w_accept    = cmd_valid && r_ready;
    assign w_step      = (r_state == S_RUN) && !pause;
    assign w_wrap_step = w_step && (r_dir_down ? (r_bin == c_ZERO) : (r_bin == c_ONES));

    always_comb begin
        w_next_bin = r_bin;
        if (w_accept) begin
            if (cmd_op == c_OP_LOAD) begin
                w_next_bin = gray2bin(cmd_load);
            end else if (cmd_op == c_OP_CLEAR) begin
                w_next_bin = c_ZERO;
            end
        end else if (w_step) begin
            w_next_bin = r_dir_down ? (r_bin - c_ONE) : (r_bin + c_ONE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_bin      <= c_ZERO;
            r_gray     <= c_ZERO;
            r_rem      <= c_REM_ZERO;
            r_dir_down <= 1'b0;
            r_ready    <= 1'b0;
            r_wrap     <= 1'b0;
        end else begin
            r_bin  <= w_next_bin;
            r_gray <= w_next_bin ^ (w_next_bin >> 1);
            r_wrap <= w_wrap_step;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_ready <= 1'b0;
                        if ((cmd_op == c_OP_UP) || (cmd_op == c_OP_DOWN)) begin
                            r_dir_down <= cmd_op[0];
                            r_rem      <= cmd_steps;
                            r_state    <= (cmd_steps != c_REM_ZERO) ? S_RUN : S_DONE;
                        end else begin
                            r_state <= S_DONE;
                        end
                    end else begin
                        r_ready <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (!pause) begin
                        r_rem <= r_rem - c_REM_ONE;
                        if (r_rem == c_REM_ONE) begin
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    assign gray      = r_gray;
    assign cmd_ready = r_ready;
    assign busy      = (r_state == S_RUN) || (r_state == S_DONE);
    assign done      = (r_state == S_DONE);
    assign wrap      = r_wrap;

`ifdef GRAY_SEQ_CHECK_EN
    logic             r_chk;
    logic             r_err;
    logic [WIDTH-1:0] r_gray_prev;
    logic [WIDTH-1:0] w_diff;

    // One cycle after a RUN step, the new and previous Gray values must differ in exactly one bit.
    assign w_diff = r_gray ^ r_gray_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_chk       <= 1'b0;
            r_err       <= 1'b0;
            r_gray_prev <= c_ZERO;
        end else begin
            r_chk       <= w_step;
            r_gray_prev <= r_gray;
            if (r_chk && ((w_diff == c_ZERO) || ((w_diff & (w_diff - c_ONE)) != c_ZERO))) begin
                r_err <= 1'b1;
            end
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gray_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_gray_seq_ctrl                                                           |
// | Self-checking bench for gray_seq_ctrl (WIDTH=4, CNT_W=8).                  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_gray_seq_ctrl;

    localparam int WIDTH = 4;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [CNT_W-1:0] cmd_steps;
    logic [WIDTH-1:0] cmd_load;
    logic             pause;
    logic [WIDTH-1:0] gray;
    logic             busy;
    logic             done;
    logic             wrap;
    logic             err;

    gray_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_steps (cmd_steps),
        .cmd_load  (cmd_load),
        .pause     (pause),
        .gray      (gray),
        .busy      (busy),
        .done      (done),
        .wrap      (wrap),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]       op;
        logic [CNT_W-1:0] steps;
        logic [WIDTH-1:0] load;
        int               pstart;
        int               plen;
        logic [WIDTH-1:0] exp_gray;
        int               exp_lat;
        int               exp_wraps;
    } vec_t;

    typedef struct {
        logic [WIDTH-1:0] gray;
        int               lat;
        int               wraps;
    } exp_t;

    exp_t             sb[$];
    vec_t             vecs[15];
    logic [WIDTH-1:0] gseq[0:31];
    int               checks = 0;
    int               errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!cmd_ready && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) chk({tag, " ready timeout"}, {31'd0, cmd_ready}, 32'd1);
    endtask

    // Drive one command, push its expectation, then pop and compare when done fires.
    task automatic do_cmd(input vec_t v, input string tag);
        int   lat;
        int   wraps;
        bit   seen;
        exp_t e;
        wait_ready(tag);
        cmd_valid = 1'b1;
        cmd_op    = v.op;
        cmd_steps = v.steps;
        cmd_load  = v.load;
        sb.push_back('{v.exp_gray, v.exp_lat, v.exp_wraps});
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        lat   = 0;
        wraps = 0;
        seen  = 1'b0;
        while (!seen && lat < 300) begin
            @(negedge clk);
            lat++;
            if (lat < 32) gseq[lat] = gray;
            if (wrap === 1'b1) wraps++;
            if (done === 1'b1) begin
                seen = 1'b1;
                e = sb.pop_front();
                chk({tag, " gray"}, {28'd0, gray}, {28'd0, e.gray});
                chk({tag, " latency"}, lat, e.lat);
                chk({tag, " wraps"}, wraps, e.wraps);
                chk({tag, " busy@done"}, {31'd0, busy}, 32'd1);
                chk({tag, " ready@done"}, {31'd0, cmd_ready}, 32'd0);
                pause = 1'b0;
            end else begin
                pause = (v.plen > 0) && (lat >= v.pstart) && (lat < v.pstart + v.plen);
            end
        end
        if (!seen) begin
            chk({tag, " done timeout"}, 32'd0, 32'd1);
            void'(sb.pop_front());
        end
        pause = 1'b0;
        @(negedge clk);
        chk({tag, " ready after"}, {31'd0, cmd_ready}, 32'd1);
        chk({tag, " done after"}, {31'd0, done}, 32'd0);
        chk({tag, " busy after"}, {31'd0, busy}, 32'd0);
    endtask

    logic [WIDTH-1:0] exp_g1[5];
    logic [WIDTH-1:0] exp_gh[5];
    logic             exp_dh[5];

    initial begin
        //         op     steps  load     ps pl  gray     lat wraps
        vecs[0]  = '{2'b00, 8'd5,  4'b0000, 0, 0, 4'b0111, 6,  0};
        vecs[1]  = '{2'b11, 8'd0,  4'b0000, 0, 0, 4'b0000, 1,  0};
        vecs[2]  = '{2'b01, 8'd1,  4'b0000, 0, 0, 4'b1000, 2,  1};
        vecs[3]  = '{2'b10, 8'd0,  4'b1100, 0, 0, 4'b1100, 1,  0};
        vecs[4]  = '{2'b00, 8'd2,  4'b0000, 0, 0, 4'b1111, 3,  0};
        vecs[5]  = '{2'b00, 8'd3,  4'b0000, 2, 3, 4'b1011, 7,  0};
        vecs[6]  = '{2'b00, 8'd0,  4'b0000, 0, 0, 4'b1011, 1,  0};
        vecs[7]  = '{2'b00, 8'd5,  4'b0000, 0, 0, 4'b0011, 6,  1};
        vecs[8]  = '{2'b01, 8'd4,  4'b0000, 0, 0, 4'b1001, 5,  1};
        vecs[9]  = '{2'b10, 8'd0,  4'b0010, 0, 0, 4'b0010, 1,  0};
        vecs[10] = '{2'b01, 8'd2,  4'b0000, 1, 2, 4'b0001, 5,  0};
        vecs[11] = '{2'b10, 8'd0,  4'b1000, 0, 0, 4'b1000, 1,  0};
        vecs[12] = '{2'b00, 8'd1,  4'b0000, 0, 0, 4'b0000, 2,  1};
        vecs[13] = '{2'b00, 8'd20, 4'b0000, 0, 0, 4'b0110, 21, 1};
        vecs[14] = '{2'b01, 8'd0,  4'b0000, 1, 1, 4'b0110, 1,  0};
        exp_g1 = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111};
        exp_gh = '{4'b0110, 4'b0111, 4'b0101, 4'b0101, 4'b0000};
        exp_dh = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_steps = '0;
        cmd_load  = '0;
        pause     = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset gray", {28'd0, gray}, 32'd0);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset done", {31'd0, done}, 32'd0);
        chk("reset wrap", {31'd0, wrap}, 32'd0);
        chk("reset err", {31'd0, err}, 32'd0);
        chk("reset ready", {31'd0, cmd_ready}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready after reset", {31'd0, cmd_ready}, 32'd1);

        for (int i = 0; i < 15; i++) begin
            do_cmd(vecs[i], $sformatf("vec%0d", i));
            if (i == 0) begin
                for (int j = 0; j < 5; j++)
                    chk($sformatf("up5 step%0d", j + 1), {28'd0, gseq[j+2]}, {28'd0, exp_g1[j]});
            end
        end

        // cmd_valid held high through a RUN: the queued CLEAR waits for cmd_ready.
        do_cmd('{2'b10, 8'd0, 4'b0110, 0, 0, 4'b0110, 1, 0}, "load4");
        wait_ready("hold");
        cmd_valid = 1'b1;
        cmd_op    = 2'b00;
        cmd_steps = 8'd2;
        @(posedge clk);
        #1 cmd_op = 2'b11;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("hold gray c%0d", c + 1), {28'd0, gray}, {28'd0, exp_gh[c]});
            chk($sformatf("hold done c%0d", c + 1), {31'd0, done}, {31'd0, exp_dh[c]});
            if (c == 3) begin
                chk("hold ready c4", {31'd0, cmd_ready}, 32'd1);
                @(posedge clk);
                #1 cmd_valid = 1'b0;
            end
        end
        chk("err after run", {31'd0, err}, 32'd0);

        // Reset in the middle of RUN_UP 10, after the fourth step.
        @(negedge clk);
        wait_ready("rstrun");
        cmd_valid = 1'b1;
        cmd_op    = 2'b00;
        cmd_steps = 8'd10;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("mid-run gray", {28'd0, gray}, 32'b0110);
        rst = 1'b1;
        #1;
        chk("rst gray", {28'd0, gray}, 32'd0);
        chk("rst busy", {31'd0, busy}, 32'd0);
        chk("rst done", {31'd0, done}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        begin
            int dseen = 0;
            repeat (12) begin
                @(negedge clk);
                if (done === 1'b1 || gray !== 4'b0000) dseen++;
            end
            chk("post-rst quiet", dseen, 32'd0);
        end
        chk("post-rst ready", {31'd0, cmd_ready}, 32'd1);
        chk("post-rst err", {31'd0, err}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
